framebuffer_scanout: RTL and testbench

- Read side of the Mandelbrot pixel memory that mandelbrot_top writes into.
- Generates 640x480@60 VGA timing and issues sequential read addresses into the 8-bit-per-pixel framebuffer, one address per active pixel.
- Maps each returned iteration byte to RGB and outputs it aligned with hsync, vsync and blank_n.
- Gated by the renderer's done level, so an incomplete frame is never shown.

---
 rtl/framebuffer_scanout.sv | 147 ++++++++++++++
 tb/tb_framebuffer_scanout.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : framebuffer_scanout
// Description : VGA scan-out of the 8-bit Mandelbrot framebuffer. Generates
//               sync timing, issues one linear read per active pixel, maps
//               the returned iteration byte to RGB and aligns it with the
//               delayed syncs. Display is gated per frame by frame_ready.
// Revision    : 1.0 - initial release
// ============================================================================
module framebuffer_scanout #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          ADDR_W       = 19,
  parameter int          RD_LATENCY   = 1,
  parameter logic [7:0]  IN_SET_VALUE = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_ready,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              mem_re,
  input  logic [7:0]        mem_read_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              blank_n,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int L       = RD_LATENCY + 1;

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END    = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Sync-side flag bits {frame_start, blank_n, vsync, hsync}; idle = syncs high
  localparam logic [3:0] SYNC_IDLE = 4'b0011;

  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d, addr_base;
  logic              den_q, den_d;
  logic              frame_first, active, en_now, hs_now, vs_now;
  logic [3:0]        sync_now;
  logic [3:0]        sync_q [L];
  logic              show_q [RD_LATENCY];
  logic [7:0]        r_d, g_d, b_d, r_q, g_q, b_q;

  // Stage 0: timing point decode, per-frame enable and linear address
  always_comb begin
    frame_first = (h_q == '0) && (v_q == '0);
    h_d         = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d         = v_q;
    if (h_q == H_LAST) begin
      v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
    end
    // frame_ready is only honoured at the frame boundary; mid-frame changes
    // wait for the next (0,0) so a partially rendered frame is never shown
    en_now      = frame_first ? frame_ready : den_q;
    den_d       = en_now;
    active      = (h_q < H_ACT_END) && (v_q < V_ACT_END);
    hs_now      = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_now      = !((v_q >= VS_BEG) && (v_q < VS_END));
    // Counter restarts at (0,0) so a frame always begins at address zero
    addr_base   = frame_first ? '0 : addr_q;
    addr_d      = addr_base + {{(ADDR_W-1){1'b0}}, active};
    sync_now    = {frame_first, active, vs_now, hs_now};
  end

  // Read request is gated by reset so it drops the moment reset asserts
  assign mem_read_address = addr_base;
  assign mem_re           = reset & active & en_now;

  // Stage 0 state: position counters, address counter and frame enable
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q    <= '0;
      v_q    <= '0;
      addr_q <= '0;
      den_q  <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      addr_q <= addr_d;
      den_q  <= den_d;
    end
  end

  // Colour map applied to the byte that arrives with this timing point
  always_comb begin
    r_d = 8'h00;
    g_d = 8'h00;
    b_d = 8'h00;
    if (show_q[RD_LATENCY-1] && (mem_read_data != IN_SET_VALUE)) begin
      r_d = mem_read_data;
      g_d = {mem_read_data[6:0], 1'b0};
      b_d = {mem_read_data[5:0], 2'b00};
    end
  end

  // Alignment pipeline: syncs delayed L clocks, display flag delayed to
  // meet the read data, colour registered once so both land together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < L; i++) sync_q[i] <= SYNC_IDLE;
      for (int i = 0; i < RD_LATENCY; i++) show_q[i] <= 1'b0;
      r_q <= 8'h00;
      g_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      sync_q[0] <= sync_now;
      for (int i = 1; i < L; i++) sync_q[i] <= sync_q[i-1];
      show_q[0] <= active & en_now;
      for (int i = 1; i < RD_LATENCY; i++) show_q[i] <= show_q[i-1];
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign hsync       = sync_q[L-1][0];
  assign vsync       = sync_q[L-1][1];
  assign blank_n     = sync_q[L-1][2];
  assign frame_start = sync_q[L-1][3];
  assign vga_r       = r_q;
  assign vga_g       = g_q;
  assign vga_b       = b_q;

endmodule
`default_nettype wire

// File: tb/tb_framebuffer_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_framebuffer_scanout
// Description : Bench for framebuffer_scanout using a reduced raster
//               (16x8 active, 25x15 total). Two instances, read latency 1
//               and 2, share clock, reset and frame_ready. A reference
//               raster model queues the expected output of every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_framebuffer_scanout;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;   // 25
  localparam int VT = VA + VF + VS + VB;   // 15
  localparam int FRAME = HT * VT;          // 375
  localparam int AW = 19;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } out_t;
  localparam out_t RST_OUT = {1'b1, 1'b1, 1'b0, 1'b0, 24'h000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, frame_ready, fill_ff;
  logic [7:0]    off;
  logic [AW-1:0] addr1, addr2;
  logic          re1, re2;
  logic [7:0]    rd1 = 8'h00, rd2a = 8'h00, rd2 = 8'h00;
  logic [7:0]    r1, g1, b1, r2, g2, b2;
  logic          hs1, vs1, bl1, fs1, hs2, vs2, bl2, fs2;

  int errors = 0;
  int checks = 0;

  framebuffer_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(AW), .RD_LATENCY(1), .IN_SET_VALUE(8'hFF)
  ) dut1 (
    .clk(clk), .reset(reset), .frame_ready(frame_ready),
    .mem_read_address(addr1), .mem_re(re1), .mem_read_data(rd1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1),
    .hsync(hs1), .vsync(vs1), .blank_n(bl1), .frame_start(fs1)
  );

  framebuffer_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .ADDR_W(AW), .RD_LATENCY(2), .IN_SET_VALUE(8'hFF)
  ) dut2 (
    .clk(clk), .reset(reset), .frame_ready(frame_ready),
    .mem_read_address(addr2), .mem_re(re2), .mem_read_data(rd2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2),
    .hsync(hs2), .vsync(vs2), .blank_n(bl2), .frame_start(fs2)
  );

  // Framebuffer contents: byte = address + off, or all 0xFF
  always @(posedge clk) rd1 <= fill_ff ? 8'hFF : addr1[7:0] + off;
  always @(posedge clk) begin
    rd2a <= fill_ff ? 8'hFF : addr2[7:0] + off;
    rd2  <= rd2a;
  end

  // Reference raster position of stage 0 and the latched frame enable
  int mh, mv;
  logic men_q;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mh <= 0; mv <= 0; men_q <= 1'b0;
    end else begin
      if (mh == 0 && mv == 0) men_q <= frame_ready;
      if (mh == HT - 1) begin
        mh <= 0;
        mv <= (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh <= mh + 1;
      end
    end
  end

  // Scoreboard: expected output per timing point pushed each cycle,
  // popped L cycles later when the DUT presents it
  out_t q1[$], q2[$];
  always @(negedge clk) begin : sb
    out_t e, x1, x2, got1, got2;
    logic fst, en, act, ere;
    int   a;
    logic [7:0] d;
    got1 = {hs1, vs1, bl1, fs1, r1, g1, b1};
    got2 = {hs2, vs2, bl2, fs2, r2, g2, b2};
    if (!reset) begin
      q1.delete(); q2.delete();
      repeat (2) q1.push_back(RST_OUT);
      repeat (3) q2.push_back(RST_OUT);
      checks += 2;
      if ({got1, re1} !== {RST_OUT, 1'b0}) begin
        errors++; $display("FAIL sb_reset1 t=%0t got=%h/%b exp=%h/0", $time, got1, re1, RST_OUT);
      end
      if ({got2, re2} !== {RST_OUT, 1'b0}) begin
        errors++; $display("FAIL sb_reset2 t=%0t got=%h/%b exp=%h/0", $time, got2, re2, RST_OUT);
      end
    end else begin
      fst = (mh == 0 && mv == 0);
      en  = fst ? frame_ready : men_q;
      act = (mh < HA) && (mv < VA);
      ere = act && en;
      a   = mv * HA + mh;
      d   = fill_ff ? 8'hFF : (8'(a) + off);
      checks += 2;
      if (re1 !== ere) begin errors++; $display("FAIL sb_re1 t=%0t (%0d,%0d) got=%b exp=%b", $time, mh, mv, re1, ere); end
      if (re2 !== ere) begin errors++; $display("FAIL sb_re2 t=%0t (%0d,%0d) got=%b exp=%b", $time, mh, mv, re2, ere); end
      if (ere) begin
        checks += 2;
        if (addr1 !== AW'(a)) begin errors++; $display("FAIL sb_addr1 t=%0t got=%0d exp=%0d", $time, addr1, a); end
        if (addr2 !== AW'(a)) begin errors++; $display("FAIL sb_addr2 t=%0t got=%0d exp=%0d", $time, addr2, a); end
      end
      e.hs = !(mh >= HA + HF && mh < HA + HF + HS);
      e.vs = !(mv >= VA + VF && mv < VA + VF + VS);
      e.bl = act;
      e.fs = fst;
      if (ere && d != 8'hFF) begin
        e.r = d; e.g = {d[6:0], 1'b0}; e.b = {d[5:0], 2'b00};
      end else begin
        e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
      end
      q1.push_back(e); q2.push_back(e);
      x1 = q1.pop_front(); x2 = q2.pop_front();
      checks += 2;
      if (got1 !== x1) begin errors++; $display("FAIL sb_out1 t=%0t got=%h exp=%h", $time, got1, x1); end
      if (got2 !== x2) begin errors++; $display("FAIL sb_out2 t=%0t got=%h exp=%h", $time, got2, x2); end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_point(input int h, input int v, input string tag);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (mh == h && mv == v) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL %s_wait got=timeout exp=(%0d,%0d)", tag, h, v); end
  endtask

  task automatic test_reset();
    reset = 1'b0; frame_ready = 1'b0; fill_ff = 1'b0; off = 8'h00;
    repeat (3) step();
    checks += 4;
    if ({hs1, vs1, bl1, fs1} !== 4'b1100) begin errors++; $display("FAIL rst_sync1 got=%b exp=1100", {hs1, vs1, bl1, fs1}); end
    if ({r1, g1, b1} !== 24'h0) begin errors++; $display("FAIL rst_rgb1 got=%h exp=0", {r1, g1, b1}); end
    if ({re1, addr1} !== '0) begin errors++; $display("FAIL rst_mem1 got=%b/%0d exp=0/0", re1, addr1); end
    if ({hs2, vs2, bl2, fs2, r2, g2, b2, re2, addr2} !== {4'b1100, 24'h0, 1'b0, 19'h0}) begin
      errors++; $display("FAIL rst_dut2 got=%b%b%b%b/%h/%b/%0d exp=1100/0/0/0", hs2, vs2, bl2, fs2, {r2, g2, b2}, re2, addr2);
    end
    step();
    reset = 1'b1;
  endtask

  task automatic test_blank_frames();
    int lowh = 0, lowv = 0, nfs = 0, nre = 0, nz = 0, run = -1, lastfall = -1, bad_w = 0, bad_p = 0;
    logic prev = 1'b1;
    for (int k = 1; k <= 2 * FRAME; k++) begin
      step();
      if (!hs1) lowh++;
      if (!vs1) lowv++;
      if (fs1) nfs++;
      if (re1 | re2) nre++;
      if ({r1, g1, b1, r2, g2, b2} != 48'h0) nz++;
      if (prev && !hs1) begin
        if (lastfall >= 0 && k - lastfall != HT) bad_p++;
        lastfall = k; run = 0;
      end
      if (!hs1 && run >= 0) run++;
      if (!prev && hs1 && run >= 0) begin
        if (run != HS) bad_w++;
        run = -1;
      end
      prev = hs1;
    end
    checks += 8;
    if (lowh != 2 * VT * HS) begin errors++; $display("FAIL blank_hlow got=%0d exp=%0d", lowh, 2 * VT * HS); end
    if (lowv != 2 * VS * HT) begin errors++; $display("FAIL blank_vlow got=%0d exp=%0d", lowv, 2 * VS * HT); end
    if (nfs != 2) begin errors++; $display("FAIL blank_fs got=%0d exp=2", nfs); end
    if (nre != 0) begin errors++; $display("FAIL blank_re got=%0d exp=0", nre); end
    if (nz != 0) begin errors++; $display("FAIL blank_rgb got=%0d exp=0", nz); end
    if (bad_w != 0) begin errors++; $display("FAIL blank_hwidth got=%0d exp=0", bad_w); end
    if (bad_p != 0) begin errors++; $display("FAIL blank_hperiod got=%0d exp=0", bad_p); end
    if (lastfall < 0) begin errors++; $display("FAIL blank_hfall got=none exp=seen"); end
  endtask

  task automatic test_display();
    int n1 = 0, n2 = 0, first = -1, last = -1, k5 = -1;
    bit seen1 = 0, seen2 = 0;
    frame_ready = 1'b1; fill_ff = 1'b0; off = 8'h00;
    wait_point(0, 0, "disp");
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) step();
      if (re1) begin
        n1++;
        if (first < 0) first = int'(addr1);
        last = int'(addr1);
        if (addr1 == 19'd5) k5 = k;
      end
      if (re2) n2++;
      if (k5 >= 0 && k == k5 + 2) begin
        seen1 = 1; checks++;
        if ({bl1, r1, g1, b1} !== {1'b1, 8'h05, 8'h0A, 8'h14}) begin
          errors++; $display("FAIL disp_pix5_l1 got=%b/%h exp=1/050a14", bl1, {r1, g1, b1});
        end
      end
      if (k5 >= 0 && k == k5 + 3) begin
        seen2 = 1; checks++;
        if ({bl2, r2, g2, b2} !== {1'b1, 8'h05, 8'h0A, 8'h14}) begin
          errors++; $display("FAIL disp_pix5_l2 got=%b/%h exp=1/050a14", bl2, {r2, g2, b2});
        end
      end
    end
    checks += 5;
    if (n1 != HA * VA) begin errors++; $display("FAIL disp_count1 got=%0d exp=%0d", n1, HA * VA); end
    if (n2 != HA * VA) begin errors++; $display("FAIL disp_count2 got=%0d exp=%0d", n2, HA * VA); end
    if (first != 0) begin errors++; $display("FAIL disp_first got=%0d exp=0", first); end
    if (last != HA * VA - 1) begin errors++; $display("FAIL disp_last got=%0d exp=%0d", last, HA * VA - 1); end
    if (!(seen1 && seen2)) begin errors++; $display("FAIL disp_pix5_seen got=%b%b exp=11", seen1, seen2); end
  endtask

  task automatic test_in_set();
    int b1n = 0, b2n = 0, nz1 = 0, nz2 = 0;
    fill_ff = 1'b1;
    wait_point(0, 0, "ff");
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) step();
      if (bl1) begin b1n++; if ({r1, g1, b1} != 24'h0) nz1++; end
      if (bl2) begin b2n++; if ({r2, g2, b2} != 24'h0) nz2++; end
    end
    checks += 4;
    if (b1n != HA * VA) begin errors++; $display("FAIL ff_blank1 got=%0d exp=%0d", b1n, HA * VA); end
    if (b2n != HA * VA) begin errors++; $display("FAIL ff_blank2 got=%0d exp=%0d", b2n, HA * VA); end
    if (nz1 != 0) begin errors++; $display("FAIL ff_rgb1 got=%0d exp=0", nz1); end
    if (nz2 != 0) begin errors++; $display("FAIL ff_rgb2 got=%0d exp=0", nz2); end
  endtask

  task automatic test_midframe_enable();
    int n = 0;
    bit found = 0;
    fill_ff = 1'b0; off = 8'h11; frame_ready = 1'b0;
    wait_point(0, 0, "mid_a");
    wait_point(0, 4, "mid_b");
    frame_ready = 1'b1;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      step();
      if (mh == 0 && mv == 0) found = 1;
      else if (re1) n++;
    end
    checks += 2;
    if (!found) begin errors++; $display("FAIL mid_boundary got=timeout exp=(0,0)"); end
    if (n != 0) begin errors++; $display("FAIL mid_raise_re got=%0d exp=0", n); end
    n = 0;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) step();
      if (re1) n++;
      if (mh == 0 && mv == 4) frame_ready = 1'b0;
    end
    checks++;
    if (n != HA * VA) begin errors++; $display("FAIL mid_full_frame got=%0d exp=%0d", n, HA * VA); end
    n = 0;
    for (int k = 0; k < FRAME; k++) begin
      step();
      if (re1 | re2) n++;
    end
    checks++;
    if (n != 0) begin errors++; $display("FAIL mid_drop_re got=%0d exp=0", n); end
  endtask

  task automatic test_rd_latency2();
    off = 8'h30; fill_ff = 1'b0; frame_ready = 1'b1;
    wait_point(0, 0, "lat");
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      if (k == 2) begin
        checks += 2;
        if ({fs1, bl1, r1, g1, b1} !== {2'b11, 8'h30, 8'h60, 8'hC0}) begin
          errors++; $display("FAIL lat1_first got=%b%b/%h exp=11/3060c0", fs1, bl1, {r1, g1, b1});
        end
        if ({fs2, bl2} !== 2'b00) begin errors++; $display("FAIL lat2_early got=%b%b exp=00", fs2, bl2); end
      end
      if (k == 3) begin
        checks++;
        if ({fs2, bl2, hs2, vs2, r2, g2, b2} !== {4'b1111, 8'h30, 8'h60, 8'hC0}) begin
          errors++; $display("FAIL lat2_first got=%b%b%b%b/%h exp=1111/3060c0", fs2, bl2, hs2, vs2, {r2, g2, b2});
        end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int nfs1 = 0, nfs2 = 0, at1 = -1, at2 = -1;
    frame_ready = 1'b1;
    wait_point(10, 4, "rstmid");
    checks++;
    if (bl1 !== 1'b1) begin errors++; $display("FAIL rstmid_pre got=%b exp=1", bl1); end
    #1 reset = 1'b0;
    #1;
    checks += 2;
    if ({hs1, vs1, bl1, fs1, r1, g1, b1, re1, addr1} !== {4'b1100, 24'h0, 1'b0, 19'h0}) begin
      errors++; $display("FAIL rstmid_async1 got=%b%b%b%b/%h/%b/%0d exp=1100/0/0/0", hs1, vs1, bl1, fs1, {r1, g1, b1}, re1, addr1);
    end
    if ({hs2, vs2, bl2, fs2, r2, g2, b2, re2, addr2} !== {4'b1100, 24'h0, 1'b0, 19'h0}) begin
      errors++; $display("FAIL rstmid_async2 got=%b%b%b%b/%h/%b/%0d exp=1100/0/0/0", hs2, vs2, bl2, fs2, {r2, g2, b2}, re2, addr2);
    end
    repeat (4) step();
    reset = 1'b1;
    #1;
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) step();
      if (k == 0) begin
        checks++;
        if ({re1, addr1} !== {1'b1, 19'h0}) begin errors++; $display("FAIL rstmid_restart got=%b/%0d exp=1/0", re1, addr1); end
      end
      if (fs1) begin nfs1++; if (at1 < 0) at1 = k; end
      if (fs2) begin nfs2++; if (at2 < 0) at2 = k; end
    end
    checks += 2;
    if (nfs1 != 1 || at1 != 2) begin errors++; $display("FAIL rstmid_fs1 got=%0d@%0d exp=1@2", nfs1, at1); end
    if (nfs2 != 1 || at2 != 3) begin errors++; $display("FAIL rstmid_fs2 got=%0d@%0d exp=1@3", nfs2, at2); end
  endtask

  initial begin
    test_reset();
    test_blank_frames();
    test_display();
    test_in_set();
    test_midframe_enable();
    test_rd_latency2();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
